// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer and the ALU control decoder:
// issuer state encoding, ALU op codes and the op legality test.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_SLT = 3'd4
  } alu_op_e;

  // An op code is legal when it does not exceed the configured highest op.
  function automatic logic op_legal(input logic [2:0] op, input int max_op);
    return ($signed({29'd0, op}) <= max_op);
  endfunction

endpackage

// File: rtl/alu_issuer.sv
// ALU issuer: accepts one request at a time, drives the operands onto an
// external combinational ALU, lets them settle, captures the result and
// presents it on a valid/ready response port. Illegal op codes are answered
// immediately with an error response and never reach the ALU.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_OP        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_operation,
  input  logic [31:0] alu_res,
  input  logic        alu_slt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_slt,
  output logic        rsp_err,
  output logic [15:0] issue_count
);

  // Last settle count value; DRIVE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
  logic        slt_q, slt_d;
  logic        err_q, err_d;
  logic [15:0] issue_count_q, issue_count_d;
  logic        accept;

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign alu_A         = a_q;
  assign alu_B         = b_q;
  assign alu_operation = op_q;
  assign rsp_res       = res_q;
  assign rsp_slt       = slt_q;
  assign rsp_err       = err_q;
  assign issue_count   = issue_count_q;

  // Next-state logic: request acceptance, settle timing, result capture and response release.
  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    res_d         = res_q;
    slt_d         = slt_q;
    err_d         = err_q;
    issue_count_d = issue_count_q;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (op_legal(req_op, MAX_OP)) begin
            // Operands are latched once here; later request changes are ignored.
            a_d      = req_a;
            b_d      = req_b;
            op_d     = req_op;
            settle_d = 4'd0;
            state_d  = ST_DRIVE;
          end else begin
            // Illegal ops bypass the ALU and leave its port untouched.
            res_d   = 32'd0;
            slt_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        res_d   = alu_res;
        slt_d   = alu_slt;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      issue_count_d = issue_count_q + 16'd1;
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      settle_q      <= 4'd0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= 3'd0;
      res_q         <= 32'd0;
      slt_q         <= 1'b0;
      err_q         <= 1'b0;
      issue_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      res_q         <= res_d;
      slt_q         <= slt_d;
      err_q         <= err_d;
      issue_count_q <= issue_count_d;
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Testbench for alu_issuer: a behavioural ALU is attached to the ALU port,
// and a transaction-level model predicts every response, its latency and
// the request count.
module tb_alu_issuer;

  localparam int S      = 1;
  localparam int MAX_OP = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_operation;
  logic [31:0] alu_res;
  logic        alu_slt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_slt;
  logic        rsp_err;
  logic [15:0] issue_count;

  int vectors;
  int miscompares;

  // Model state: requests accepted and the last legal request sent to the ALU.
  logic [15:0] m_count;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_op;

  alu_issuer #(
    .SETTLE_CYCLES(S),
    .MAX_OP       (MAX_OP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_operation(alu_operation),
    .alu_res      (alu_res),
    .alu_slt      (alu_slt),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_slt      (rsp_slt),
    .rsp_err      (rsp_err),
    .issue_count  (issue_count)
  );

  // Behavioural ALU function: AND, OR, ADD, SUB, signed set-less-than.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return {31'd0, ($signed(a) < $signed(b))};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_A, alu_B, alu_operation);
  assign alu_slt = ($signed(alu_A) < $signed(alu_B));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction. Entered and left at #1 after a rising edge with the DUT idle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int hold);
    logic        legal;
    int          n;
    logic [31:0] e_res;
    logic        e_slt;
    logic        e_err;
    legal = (int'(op) <= MAX_OP);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    m_count = m_count + 16'd1;
    if (legal) begin
      m_a = a; m_b = b; m_op = op;
      e_res = alu_fn(a, b, op);
      e_slt = ($signed(a) < $signed(b));
      e_err = 1'b0;
    end else begin
      e_res = 32'd0;
      e_slt = 1'b0;
      e_err = 1'b1;
    end
    // Scramble the request bus: the issuer must already hold its own copy.
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 3'($urandom_range(0, 7));
    n = 1;
    while (!rsp_valid && n < 40) begin
      chk("busy_req_ready", req_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, legal ? (S + 2) : 1);
    chk("rsp_res", rsp_res, e_res);
    chk("rsp_slt", rsp_slt, e_slt);
    chk("rsp_err", rsp_err, e_err);
    chk("issue_count", issue_count, m_count);
    chk("alu_A_held", alu_A, m_a);
    chk("alu_B_held", alu_B, m_b);
    chk("alu_op_held", alu_operation, m_op);
    if (hold > 0) begin
      // A competing request must not be accepted while the response waits.
      req_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_res", rsp_res, e_res);
        chk("hold_slt", rsp_slt, e_slt);
        chk("hold_err", rsp_err, e_err);
        chk("hold_req_ready", req_ready, 0);
        chk("hold_count", issue_count, m_count);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_done_valid", rsp_valid, 0);
    chk("rsp_done_ready", req_ready, 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_a       = 32'd0;
    req_b       = 32'd0;
    req_op      = 3'd0;
    rsp_ready   = 1'b0;
    m_count     = 16'd0;
    m_a         = 32'd0;
    m_b         = 32'd0;
    m_op        = 3'd0;

    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_alu_op", alu_operation, 0);
    chk("rst_count", issue_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ops 0-4 back to back with the response side always ready.
    for (int i = 0; i < 5; i++) issue(32'd100, 32'd200, 3'(i), 0);
    chk("b2b_count", issue_count, 16'd5);

    // Reference ADD, then an illegal op, then a long response stall.
    issue(32'd100, 32'd200, 3'd2, 0);
    issue(32'd100, 32'd200, 3'd7, 0);
    issue(32'h1234_5678, 32'h0000_9abc, 3'd3, 10);

    // Randomized mix of legal/illegal ops, operands and stall lengths.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      ra  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      rb  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      rop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      issue(ra, rb, rop, $urandom_range(0, 3));
    end

    // Reset while the operands are being driven: everything clears, no response follows.
    req_valid = 1'b1;
    req_a     = 32'd7;
    req_b     = 32'd9;
    req_op    = 3'd3;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_count = 16'd0; m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_res", rsp_res, 0);
    chk("mid_rst_rsp_slt", rsp_slt, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    chk("mid_rst_alu_A", alu_A, 0);
    chk("mid_rst_alu_B", alu_B, 0);
    chk("mid_rst_alu_op", alu_operation, 0);
    chk("mid_rst_count", issue_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    chk("post_rst_ready", req_ready, 1);

    // Preload the count near its limit, then accept requests across the wrap.
    force dut.issue_count_q = 16'hFFFE;
    #1;
    release dut.issue_count_q;
    m_count = 16'hFFFE;
    chk("preload_count", issue_count, 16'hFFFE);
    issue(32'd5, 32'd3, 3'd1, 0);
    issue(32'd5, 32'd3, 3'd6, 0);
    chk("wrap_count", issue_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
